fifo_tick_loop: RTL
===================

# fifo_tick_loop

Downstream consumer of the 1 kHz divider output in the FIFO exercise chain. Samples the divider's slow `clk_1k` level in the system clock domain, edge-detects it into a one-cycle tick, and paces an internal synchronous FIFO through a fill-then-drain loop at one word per tick. Exposes FIFO write and read activity as registered outputs, making FIFO behaviour at human-visible rates observable on LEDs or a logic analyser.

## Interface
- `DATA_W`, 8: FIFO word width.
- `DEPTH`, 16: FIFO depth in words; power of two, ≥2.
- `ADDR_W`, 4: log2(`DEPTH`).
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `clk_1k`  in  1  slow clock level from the divider; generated by a `clk`-driven flop, so no synchroniser is required.
- `en`  in  1  loop enable.
- `wr_en`  out  1  one-cycle FIFO write strobe.
- `wr_data`  out  `DATA_W`  word written.
- `rd_en`  out  1  one-cycle FIFO read strobe.
- `rd_data`  out  `DATA_W`  word read.
- `rd_valid`  out  1  one-cycle qualifier for `rd_data`.
- `full`  out  1  usedw == `DEPTH`.
- `empty`  out  1  usedw == 0.
- `usedw`  out  `ADDR_W`+1  words stored, 0..`DEPTH`.
- `state`  out  2  0 = IDLE, 1 = FILL, 2 = DRAIN.

## Operation
- Edge detect:
  - `clk_1k_d` <= `clk_1k`, reset 0.
  - tick = `clk_1k` & ~`clk_1k_d`.
  - A falling edge or a held level produces no tick.
- FSM, evaluated only in tick cycles:
  - IDLE: en=1 → FILL, with no write. en=0 → stay.
  - FILL: full=0 → issue one write, stay. full=1 → DRAIN, with no write.
  - DRAIN: empty=0 → issue one read, stay. empty=1 and en=1 → FILL. empty=1 and en=0 → IDLE.
  - `en` is sampled only in IDLE and at the DRAIN-empty decision. Deasserting `en` mid-phase lets the current FILL/DRAIN run to completion.
- Write data:
  - `wr_cnt` (`DATA_W` bits) is presented on `wr_data` and incremented after each write.
  - It wraps modulo 2^`DATA_W` and is not cleared between loops.
- FIFO:
  - Dual-pointer RAM, `ADDR_W`-bit pointers wrapping at `DEPTH`.
  - `usedw` is a counter: +1 on write, −1 on read.
  - Write and read never coincide, because the FSM issues at most one per tick. Write-when-full and read-when-empty cannot occur by construction.
  - Regardless, a write is ignored when full and a read is ignored when empty.
- Reset values:
  - all strobes and data 0
  - `usedw` 0, `full` 0, `empty` 1, `state` IDLE
  - pointers 0, `wr_cnt` 0
- Reset mid-operation:
  - Contents are discarded and all of the above is restored immediately.
  - The first tick after release with en=1 enters FILL; `wr_data` restarts at 0.

## Timing
- Cycle T = tick cycle; FSM state updates at the end of T.
- Write path:
  - `wr_en`=1 and `wr_data` valid in T+1; the word is stored at the end of T+1.
  - `usedw`/`full`/`empty` update in T+2.
- Read path:
  - `rd_en`=1 in T+1.
  - `rd_data` and `rd_valid`=1 in T+2; `rd_valid` is high for one cycle.
  - `rd_data` holds its last value afterwards.
  - `usedw`/`empty` update in T+2.
- Minimum tick spacing is 4 `clk` cycles, so flags are settled before the next decision. At 1 kHz there are 50 000 cycles between ticks.
- Loop period at en=1: 1 (IDLE→FILL) + `DEPTH` writes + 1 (full detect) + `DEPTH` reads + 1 (empty detect) ticks for the first loop. Later loops take 2·`DEPTH`+2 ticks.

## Test plan
- Reset: assert `rst_n`=0 mid-run → `state`=0, `usedw`=0, `empty`=1, `full`=0, `wr_en`=`rd_en`=`rd_valid`=0, all within the same cycle.
- Full loop, default parameters:
  - Stimulus: `en`=1, `clk_1k` toggling every 4 cycles.
  - Writes: tick 1 enters FILL; ticks 2–17 write 0..15; `full`=1 after the 16th write.
  - Reads: tick 18 enters DRAIN; ticks 19–34 give `rd_data` 0..15 in order, each with a one-cycle `rd_valid` at T+2.
  - Wrap: tick 35 sees empty and enters FILL; the next write is 16.
- Enable drop: set `en`=0 during DRAIN → all remaining words are read, then `state`=IDLE. Further ticks produce no `wr_en`.
- Reset mid-FILL after 5 writes → `usedw` 0. After release and a tick, FILL resumes with `wr_data`=0; no stale words are read.
- Edge detect: hold `clk_1k` high for 100 cycles, then low → exactly one tick and one action. No action on the falling edge.
- Wrap: with `DATA_W`=4 and `DEPTH`=4, run 5 loops → `wr_data` wraps 15→0. Pointers wrap every 4 words and read order is preserved across the wrap.

Source files
------------

// File: rtl/fifo_tick_loop.sv
// Purpose: edge-detects the slow clk_1k level into a one-cycle tick and runs an
//          internal synchronous FIFO through a fill-then-drain loop, one word per tick.
// Latency: strobes one cycle after the tick; rd_data/rd_valid and usedw/full/empty two cycles after.
// Backpressure: none; the FSM never writes when full or reads when empty, and the FIFO ignores such requests anyway.
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   clk_1k, en          slow divider level (already in clk domain), loop enable
//   wr_en, wr_data      registered write strobe and word written
//   rd_en               registered read strobe
//   rd_data, rd_valid   read word and its one-cycle qualifier
//   full, empty, usedw  FIFO occupancy
//   state               0 IDLE, 1 FILL, 2 DRAIN
module fifo_tick_loop #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_1k,
    input  logic              en,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   usedw,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [ADDR_W:0]   FULL_LVL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [DATA_W-1:0] DAT_ONE  = DATA_W'(1);

    // Edge detect: clk_1k is produced by a clk-domain flop, so one delay stage suffices.
    logic clk_1k_q;
    logic tick;

    state_e state_q, state_d;
    logic   wr_req, rd_req;
    logic   wr_en_q, rd_en_q;

    logic [DATA_W-1:0] wr_cnt_q;
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   usedw_q, usedw_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic do_wr, do_rd;

    assign tick = clk_1k & ~clk_1k_q;

    assign full  = (usedw_q == FULL_LVL);
    assign empty = (usedw_q == '0);

    // Safety guards: the FSM already prevents these, but the FIFO stays consistent regardless.
    assign do_wr = wr_en_q & ~full;
    assign do_rd = rd_en_q & ~empty;

    // FSM decisions happen only in tick cycles; en matters only in IDLE and at DRAIN-empty.
    always_comb begin
        state_d = state_q;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (en) state_d = ST_FILL;
                end
                ST_FILL: begin
                    if (full) state_d = ST_DRAIN;
                    else      wr_req  = 1'b1;
                end
                ST_DRAIN: begin
                    if (!empty)  rd_req  = 1'b1;
                    else if (en) state_d = ST_FILL;
                    else         state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        usedw_d = usedw_q;
        if (do_wr && !do_rd)      usedw_d = usedw_q + CNT_ONE;
        else if (do_rd && !do_wr) usedw_d = usedw_q - CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_1k_q   <= 1'b0;
            state_q    <= ST_IDLE;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            wr_cnt_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            usedw_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            clk_1k_q   <= clk_1k;
            state_q    <= state_d;
            wr_en_q    <= wr_req;
            rd_en_q    <= rd_req;
            usedw_q    <= usedw_d;
            rd_valid_q <= do_rd;
            if (do_wr) begin
                wr_cnt_q <= wr_cnt_q + DAT_ONE;
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_rd) begin
                rd_data_q <= mem[rd_ptr_q];
                rd_ptr_q  <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Storage is not reset: resetting the pointers and usedw discards the contents.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= wr_cnt_q;
    end

    assign wr_en    = wr_en_q;
    assign wr_data  = wr_cnt_q;
    assign rd_en    = rd_en_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign usedw    = usedw_q;
    assign state    = state_q;

endmodule
